// File: rtl/stm32_bus_pkg.sv
// Command codes, per-command payload lengths and FSM state encoding for the DATA_BUS master.
package stm32_bus_pkg;

  localparam logic [7:0] CMD_BUS_TEST   = 8'd0;
  localparam logic [7:0] CMD_SET_PARAMS = 8'd1;
  localparam logic [7:0] CMD_GET_PARAMS = 8'd2;
  localparam logic [7:0] CMD_TX_IQ      = 8'd3;
  localparam logic [7:0] CMD_RX_IQ      = 8'd4;
  localparam logic [7:0] CMD_RESET_ON   = 8'd5;
  localparam logic [7:0] CMD_RESET_OFF  = 8'd6;
  localparam logic [7:0] CMD_FLASH      = 8'd7;
  localparam logic [7:0] CMD_INFO       = 8'd8;

  localparam int LEN_SET_PARAMS = 21;
  localparam int LEN_GET_PARAMS = 10;
  localparam int LEN_TX_IQ      = 6;
  localparam int LEN_RX_IQ_ONE  = 6;
  localparam int LEN_RX_IQ_TWO  = 12;
  localparam int LEN_INFO       = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SYNC,
    ST_WRITE,
    ST_TURN,
    ST_READ,
    ST_DONE
  } state_t;

endpackage

// File: rtl/stm32_bus_master_buf.sv
// Write-payload staging buffer: write at wr_ptr, combinational read at an internal index.
// clr rewinds both pointers for the next transaction; contents are wiped only by reset.
module stm32_bus_master_buf #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [7:0]       wr_dat,
  input  logic             rd_adv,
  output logic [LEN_W-1:0] wr_ptr,
  output logic [7:0]       rd_dat
);

  localparam int AW = $clog2(MAX_LEN);

  logic [7:0]    mem [MAX_LEN];
  logic [AW-1:0] rd_idx;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_LEN; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_idx <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_idx <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= wr_dat;
        wr_ptr              <= wr_ptr + LEN_W'(1);
      end
      if (rd_adv) rd_idx <= rd_idx + AW'(1);
    end
  end

  assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/stm32_bus_master.sv
// DATA_BUS initiator: buffers write payload, strobes DATA_SYNC with the command, then streams 1 byte/clk.
// Read bytes appear on rd_data 3 clocks after the sync period; no stalls. Optional STM32_BUS_MASTER_STATS_EN.
module stm32_bus_master
  import stm32_bus_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_code,
  input  logic             cmd_dir,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             done,
  output logic             busy,
  output logic             DATA_SYNC,
  inout  wire  [7:0]       DATA_BUS
`ifdef STM32_BUS_MASTER_STATS_EN
  ,
  input  logic             stat_clear,
  output logic [15:0]      stat_xfers,
  output logic [15:0]      stat_clamped
`endif
);

  state_t           state;
  logic [7:0]       code;
  logic [7:0]       bus_out;
  logic             dir;
  logic             bus_oe;
  logic             len_clamped;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_m1;
  logic [LEN_W-1:0] len_in;
  logic [LEN_W-1:0] bcnt;
  logic [LEN_W-1:0] wr_ptr;
  logic [7:0]       buf_rd;
  logic             accept;
  logic             over;
  logic             buf_clr;
  logic             buf_wr;
  logic             buf_adv;

  assign over    = cmd_len > LEN_W'(MAX_LEN);
  assign len_in  = over ? LEN_W'(MAX_LEN) : cmd_len;
  assign len_m1  = len - LEN_W'(1);
  assign accept  = cmd_valid & cmd_ready;
  assign buf_clr = (state == ST_IDLE);
  assign buf_wr  = wr_valid & wr_ready;
  // Read index moves in lockstep with bus_out so the next byte is already addressed.
  assign buf_adv = (state == ST_SYNC) | (state == ST_WRITE);

  assign DATA_BUS = bus_oe ? bus_out : 8'bz;

  stm32_bus_master_buf #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_buf (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .clr     (buf_clr),
    .wr_en   (buf_wr),
    .wr_dat  (wr_data),
    .rd_adv  (buf_adv),
    .wr_ptr  (wr_ptr),
    .rd_dat  (buf_rd)
  );

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cmd_ready   <= 1'b0;
      wr_ready    <= 1'b0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      DATA_SYNC   <= 1'b0;
      bus_oe      <= 1'b0;
      bus_out     <= '0;
      code        <= '0;
      dir         <= 1'b0;
      len         <= '0;
      bcnt        <= '0;
      len_clamped <= 1'b0;
    end else begin
      rd_valid    <= 1'b0;
      done        <= 1'b0;
      len_clamped <= len_clamped | (accept & over);
      case (state)
        ST_IDLE: begin
          cmd_ready <= ~accept;
          if (accept) begin
            busy <= 1'b1;
            code <= cmd_code;
            dir  <= cmd_dir;
            len  <= len_in;
            if (!cmd_dir && len_in != '0) begin
              state    <= ST_LOAD;
              wr_ready <= 1'b1;
            end else begin
              state     <= ST_SYNC;
              DATA_SYNC <= 1'b1;
              bus_oe    <= 1'b1;
              bus_out   <= cmd_code;
            end
          end
        end
        ST_LOAD: begin
          if (buf_wr && wr_ptr == len_m1) begin
            wr_ready  <= 1'b0;
            state     <= ST_SYNC;
            DATA_SYNC <= 1'b1;
            bus_oe    <= 1'b1;
            bus_out   <= code;
          end
        end
        ST_SYNC: begin
          DATA_SYNC <= 1'b0;
          bcnt      <= '0;
          if (len == '0) begin
            state  <= ST_DONE;
            done   <= 1'b1;
            busy   <= 1'b0;
            bus_oe <= 1'b0;
          end else if (!dir) begin
            state   <= ST_WRITE;
            bus_out <= buf_rd;
          end else begin
            state  <= ST_TURN;
            bus_oe <= 1'b0;
          end
        end
        ST_WRITE: begin
          if (bcnt == len_m1) begin
            state  <= ST_DONE;
            done   <= 1'b1;
            busy   <= 1'b0;
            bus_oe <= 1'b0;
          end else begin
            bus_out <= buf_rd;
            bcnt    <= bcnt + LEN_W'(1);
          end
        end
        ST_TURN: state <= ST_READ;
        ST_READ: begin
          rd_data  <= DATA_BUS;
          rd_valid <= 1'b1;
          bcnt     <= bcnt + LEN_W'(1);
          if (bcnt == len_m1) begin
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef STM32_BUS_MASTER_STATS_EN
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      stat_xfers   <= '0;
      stat_clamped <= '0;
    end else if (stat_clear) begin
      stat_xfers   <= '0;
      stat_clamped <= '0;
    end else begin
      if (state == ST_DONE) stat_xfers <= stat_xfers + 16'd1;
      if (accept && over && stat_clamped != 16'hFFFF) stat_clamped <= stat_clamped + 16'd1;
    end
  end
`endif

endmodule

// File: doc/stm32_bus_master.md
Name: stm32_bus_master

Overview:
- Initiator end of the 8-bit DATA_BUS / DATA_SYNC parallel protocol.
- Replaces the MCU in FPGA-side self-test and loopback builds, and drives the bus from an embedded controller.
- Accepts one command descriptor, prefetches all write bytes into a local buffer, issues the command byte with DATA_SYNC, then streams write bytes out or captures read bytes at one byte per clock.
- The responder never stalls, so the master never stalls mid-transaction.

Parameters:
- MAX_LEN, 32, maximum payload bytes per transaction (write or read).
- LEN_W, 6, width of length fields; must satisfy 2^LEN_W > MAX_LEN.

Ports:
- clk_in  input  1  bus clock, shared with responder.
- reset_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command descriptor valid.
- cmd_ready  output  1  master idle, descriptor accepted when cmd_valid & cmd_ready.
- cmd_code  input  8  command byte (0..8 per protocol).
- cmd_dir  input  1  1 = read payload (responder drives), 0 = write payload.
- cmd_len  input  LEN_W  payload byte count, 0..MAX_LEN.
- wr_data  input  8  write payload byte.
- wr_valid  input  1  write byte valid.
- wr_ready  output  1  buffer accepting write bytes.
- rd_data  output  8  captured read byte.
- rd_valid  output  1  one-cycle strobe per captured byte, no backpressure.
- done  output  1  one-cycle pulse, transaction complete.
- busy  output  1  high from descriptor accept until done.
- DATA_SYNC  output  1  command strobe to responder.
- DATA_BUS  inout  8  shared bidirectional bus.

Behaviour:
- Reset values: cmd_ready=0 during reset, 1 after; wr_ready=0, rd_data=0, rd_valid=0, done=0, busy=0, DATA_SYNC=0, DATA_BUS released (Z).
- All outputs are registered.
- Reset mid-transaction releases the bus and drops DATA_SYNC on the reset edge, clears the buffer and counters, and discards partial read data with no done pulse.
- FSM states: IDLE, LOAD, SYNC, WRITE, TURN, READ, DONE.
- IDLE:
  - cmd_ready=1; on handshake, latch code, dir and len (clamped to MAX_LEN); set busy.
  - Next state: LOAD if dir=0 and len>0, else SYNC.
- LOAD:
  - wr_ready=1; each wr_valid&wr_ready writes wr_data to buffer[wcnt] and increments wcnt.
  - When wcnt reaches len-1 and a byte is accepted, go to SYNC; wr_ready=0 in the following cycle.
  - Bytes offered outside LOAD are ignored.
- SYNC (bus period 0): DATA_SYNC=1 and DATA_BUS driven with the command byte for exactly one clock.
- Next state from SYNC:
  - DONE if len=0.
  - WRITE if dir=0.
  - TURN if dir=1, with the bus released at the same edge.
- WRITE: during bus period i+1 drive buffer[i] for i = 0..len-1, one byte per clock, no gaps. After the last byte, release the bus and go to DONE.
- TURN: bus period 1. Master is tristated; the responder loads its first byte at the end of this period.
- READ:
  - Sample DATA_BUS at the edge ending bus period i+2 for i = 0..len-1.
  - On the following cycle, present the byte on rd_data with rd_valid=1.
  - Read data latency is two periods after the command edge plus one output register.
- DONE: done=1 for one clock, busy=0, then IDLE.
- Bus ownership: the master drives only in SYNC and WRITE. There is no cycle where master and responder both drive under correct sequencing.
- cmd_len > MAX_LEN is clamped to MAX_LEN and sets sticky internal flag len_clamped, which is cleared on reset.
- Streaming commands (RX IQ, bus test) end after cmd_len bytes; a fresh DATA_SYNC restarts the responder.
- cmd_valid held during busy is not accepted; no queueing.
- Minimum idle gap between transactions: one clock (DONE).

Optional Feature:
- Macro: STM32_BUS_MASTER_STATS_EN.
- Defined:
  - Adds outputs stat_xfers [15:0] (completed transactions, wraps at 65535→0) and stat_clamped [15:0] (clamped descriptors, saturates at 65535).
  - Adds input stat_clear (synchronous clear; wins over a simultaneous increment).
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package stm32_bus_pkg holds:
  - command code constants: CMD_BUS_TEST=0, CMD_SET_PARAMS=1, CMD_GET_PARAMS=2, CMD_TX_IQ=3, CMD_RX_IQ=4, CMD_RESET_ON=5, CMD_RESET_OFF=6, CMD_FLASH=7, CMD_INFO=8;
  - per-command payload lengths: SET_PARAMS 21, GET_PARAMS 10, TX_IQ 6, RX_IQ 6 or 12 (6 per receiver), INFO 3;
  - the FSM state enum.
- One sub-module: stm32_bus_master_buf, a MAX_LEN×8 write buffer with write pointer and read index.

Test Plan:
- CMD_INFO read, len=3, responder model attached → DATA_SYNC pulses once with bus=0x08; rd_data sequence 0x03, 0x06, 0x00; done after third rd_valid.
- CMD_TX_IQ write, len=6, bytes 12 34 56 9A BC DE offered with wr_valid gaps → on bus periods 1..6 the bus shows exactly those bytes with no gaps; responder TX_Q=0x123456, TX_I=0x9ABCDE, tx_iq_valid=1.
- CMD_RESET_ON, len=0 → single SYNC period with bus=0x05, done next clock; responder reset_n falls on the following adcclk negedge.
- cmd_len=40 with MAX_LEN=32 → exactly 32 bytes transferred and len_clamped=1; with STM32_BUS_MASTER_STATS_EN, stat_clamped=1 and stat_xfers=1.
- reset_n asserted during WRITE byte 3 → DATA_SYNC=0 and bus=Z immediately; no done pulse; after release cmd_ready=1 and the next CMD_INFO transaction is correct.
- Bus contention monitor across 1000 random transactions → never both master and responder OE high; no X on DATA_BUS during sampling edges.
